// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode pipeline stage with one-hot select, load-use bubble and HALT hold
//
// Optional feature macro: DECODE_STATS_EN
//   defined   : stat_instr / stat_bubble count accepted instructions / transferred bubbles
//   undefined : counters absent, both outputs tied to 0
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   in_valid, in_ready, instr fetch-side handshake and 32-bit instruction
//   out_valid, out_ready      execute-side handshake
//   select                    one-hot operation select (SEL_W bits)
//   rs1, rs2, rd, imm16       register indices and raw immediate
//   flush                     drop held bundle and pending bubble
//   resume                    leave HALT
//   illegal                   one-cycle pulse when an illegal opcode is accepted
//   halted                    high while in HALT
//   stat_instr, stat_bubble   statistics counters (CNT_W bits)

module instr_decode_stage #(
  parameter int SEL_W = 20,
  parameter int OPC_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] select,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [15:0]      imm16,
  input  logic             flush,
  input  logic             resume,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] stat_instr,
  output logic [CNT_W-1:0] stat_bubble
);

  localparam int OP_LOAD = 2;
  localparam int OP_NOP  = 11;
  localparam int OP_HALT = 17;

  localparam logic [OPC_W-1:0] NUM_OPS = OPC_W'(SEL_W);
  localparam logic [SEL_W-1:0] NOP_SEL = SEL_W'(1) << OP_NOP;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t state_q, state_d;

  logic             bubble_pend;
  logic             ld_live_q;   // a LOAD with rd!=0 transferred last cycle and the slot emptied
  logic [4:0]       ld_rd_q;

  logic [OPC_W-1:0] opc;
  logic [4:0]       in_rs1, in_rs2, dec_rd;
  logic             legal, r_type;
  logic [SEL_W-1:0] dec_sel;
  logic             held_load, haz_on, hazard;
  logic [4:0]       haz_rd;
  logic             slot_free, base_ready, accept, take, insert_bubble, xfer;

  assign opc    = instr[31:26];
  assign in_rs1 = instr[25:21];
  assign in_rs2 = instr[20:16];
  assign legal  = (opc < NUM_OPS);

  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < SEL_W; i++) begin
      dec_sel[i] = legal && (opc == OPC_W'(i));
    end
    if (!legal) begin
      dec_sel = NOP_SEL;
    end
  end

  always_comb begin
    r_type = 1'b0;
    case (opc)
      OPC_W'(0), OPC_W'(1), OPC_W'(4), OPC_W'(5),
      OPC_W'(6), OPC_W'(12), OPC_W'(18), OPC_W'(19): r_type = 1'b1;
      default: r_type = 1'b0;
    endcase
  end

  assign dec_rd = r_type ? instr[15:11] : instr[20:16];

  // The load whose result may be needed is either the bundle still in the
  // output register, or the one that left it on the previous edge.
  assign held_load = out_valid && select[OP_LOAD] && (rd != 5'd0);
  assign haz_on    = out_valid ? held_load : ld_live_q;
  assign haz_rd    = out_valid ? rd : ld_rd_q;
  assign hazard    = legal && haz_on && ((in_rs1 == haz_rd) || (in_rs2 == haz_rd));

  assign slot_free  = !out_valid || out_ready;
  assign base_ready = (state_q == ST_RUN) && !bubble_pend && slot_free;
  // A hazardous instruction is not consumed, so ready is withheld for it.
  assign in_ready      = base_ready && !hazard;
  assign accept        = in_valid && in_ready;
  assign take          = accept && !flush;
  assign insert_bubble = in_valid && base_ready && hazard && !flush;
  assign xfer          = out_valid && out_ready;

  assign halted = (state_q == ST_HALT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (take && (opc == OPC_W'(OP_HALT))) state_d = ST_HALT;
      ST_HALT: if (resume) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      select      <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      imm16       <= '0;
      illegal     <= 1'b0;
      bubble_pend <= 1'b0;
      ld_live_q   <= 1'b0;
      ld_rd_q     <= '0;
    end else begin
      illegal   <= take && !legal;
      ld_live_q <= !flush && xfer && held_load;
      ld_rd_q   <= rd;
      if (flush) begin
        out_valid   <= 1'b0;
        bubble_pend <= 1'b0;
      end else if (take) begin
        out_valid <= 1'b1;
        select    <= dec_sel;
        rs1       <= in_rs1;
        rs2       <= in_rs2;
        rd        <= dec_rd;
        imm16     <= instr[15:0];
      end else if (insert_bubble) begin
        out_valid   <= 1'b1;
        bubble_pend <= 1'b1;
        select      <= NOP_SEL;
        rs1         <= '0;
        rs2         <= '0;
        rd          <= '0;
        imm16       <= '0;
      end else if (xfer) begin
        out_valid   <= 1'b0;
        bubble_pend <= 1'b0;
      end
    end
  end

`ifdef DECODE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_instr  <= '0;
      stat_bubble <= '0;
    end else begin
      if (take) begin
        stat_instr <= stat_instr + CNT_W'(1);
      end
      if (xfer && bubble_pend) begin
        stat_bubble <= stat_bubble + CNT_W'(1);
      end
    end
  end
`else
  assign stat_instr  = '0;
  assign stat_bubble = '0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - scoreboard bench for instr_decode_stage

module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] select;
  logic [4:0]  rs1, rs2, rd;
  logic [15:0] imm16;
  logic        flush;
  logic        resume;
  logic        illegal;
  logic        halted;
  logic [15:0] stat_instr;
  logic [15:0] stat_bubble;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .select(select), .rs1(rs1), .rs2(rs2), .rd(rd), .imm16(imm16),
    .flush(flush), .resume(resume), .illegal(illegal), .halted(halted),
    .stat_instr(stat_instr), .stat_bubble(stat_bubble)
  );

  typedef logic [50:0] bundle_t;

  bundle_t sb[$];
  int      n_cmp = 0;
  int      n_err = 0;

`ifdef DECODE_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  function automatic bundle_t mk(input logic [19:0] s, input logic [4:0] a,
                                 input logic [4:0] b, input logic [4:0] d,
                                 input logic [15:0] im);
    return {s, a, b, d, im};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer on the output side is matched against the queue.
  bundle_t got;
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      got = {select, rs1, rs2, rd, imm16};
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got 0x%0h expected no transfer", got);
      end else begin
        chk("bundle", got, sb.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] w);
    int   cyc;
    logic acc;
    instr    = w;
    in_valid = 1'b1;
    cyc      = 0;
    acc      = 1'b0;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: instr 0x%08h never accepted, required accept within 50 cycles", w);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  localparam logic [31:0] I_ADD   = 32'h0022_1800;
  localparam logic [31:0] I_ADDI  = 32'h2424_FFFF;
  localparam logic [31:0] I_LOAD  = 32'h0825_0000;
  localparam logic [31:0] I_ADD5  = 32'h00A2_1800;
  localparam logic [31:0] I_ILL   = 32'hFC00_0000;
  localparam logic [31:0] I_HALT  = 32'h4400_0000;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    resume    = 1'b0;
    do_reset();

    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_select", 64'(select), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_stats", 64'({stat_instr, stat_bubble}), 64'd0);

    // 1: R-type ADD, one-cycle latency, valid drops afterwards
    sb.push_back(mk(20'h00001, 5'd1, 5'd2, 5'd3, 16'h1800));
    send(I_ADD);
    chk("add_latency", 64'(out_valid), 64'd1);
    chk("add_no_illegal", 64'(illegal), 64'd0);
    @(posedge clk); #1;
    chk("add_valid_drop", 64'(out_valid), 64'd0);
    drain();

    // 2: ADDI held under backpressure
    out_ready = 1'b0;
    sb.push_back(mk(20'h00200, 5'd1, 5'd4, 5'd4, 16'hFFFF));
    send(I_ADDI);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_bundle", 64'({select, rs1, rs2, rd, imm16}),
          64'(mk(20'h00200, 5'd1, 5'd4, 5'd4, 16'hFFFF)));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // 3: load-use bubble
    do_reset();
    sb.push_back(mk(20'h00004, 5'd1, 5'd5, 5'd5, 16'h0000));
    send(I_LOAD);
    sb.push_back(mk(20'h00800, 5'd0, 5'd0, 5'd0, 16'h0000));
    sb.push_back(mk(20'h00001, 5'd5, 5'd2, 5'd3, 16'h1800));
    send(I_ADD5);
    drain();
    @(posedge clk); #1;
    chk("stat_instr_lu", 64'(stat_instr), 64'(2 * STATS_ON));
    chk("stat_bubble_lu", 64'(stat_bubble), 64'(1 * STATS_ON));

    // 4: illegal opcode decodes as NOP with a one-cycle pulse
    sb.push_back(mk(20'h00800, 5'd0, 5'd0, 5'd0, 16'h0000));
    send(I_ILL);
    chk("illegal_pulse", 64'(illegal), 64'd1);
    @(posedge clk); #1;
    chk("illegal_clear", 64'(illegal), 64'd0);
    drain();

    // 5: HALT holds for 10 cycles until resume
    sb.push_back(mk(20'h20000, 5'd0, 5'd0, 5'd0, 16'h0000));
    send(I_HALT);
    for (int i = 0; i < 10; i++) begin
      chk("halt_halted", 64'(halted), 64'd1);
      chk("halt_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    chk("resume_in_ready", 64'(in_ready), 64'd1);
    chk("resume_halted", 64'(halted), 64'd0);
    drain();

    // 6a: asynchronous reset while a bubble is held
    sb.push_back(mk(20'h00004, 5'd1, 5'd5, 5'd5, 16'h0000));
    send(I_LOAD);
    instr    = I_ADD5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bubble_held_valid", 64'(out_valid), 64'd1);
    chk("bubble_held_select", 64'(select), 64'h00800);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_select", 64'(select), 64'd0);
    chk("async_rst_halted", 64'(halted), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 6b: flush drops the held bundle and a same-cycle accept
    send(I_ADD);
    chk("pre_flush_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    flush    = 1'b1;
    instr    = I_ADDI;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_accept_drop", 64'(out_valid), 64'd0);
    chk("flush_stat_instr", 64'(stat_instr), 64'(1 * STATS_ON));

    // recovery after flush
    out_ready = 1'b1;
    sb.push_back(mk(20'h00200, 5'd1, 5'd4, 5'd4, 16'hFFFF));
    send(I_ADDI);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
